control_necesidades: RTL and testbench
======================================

CONTROL_NECESIDADES -- requirements
Module: control_necesidades

Interface
REQ-001 The block SHALL have parameter TICKS_DECAY, default 1000, giving the number of clk cycles per decay step (minimum 2).
REQ-002 The block SHALL have parameter ACCION_CICLOS, default 16, giving the number of cycles one granted action is shown (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Boton_Comida  input  1  feed request, level signal already synchronous to clk.
REQ-006 Boton_Dormir  input  1  sleep request, level signal already synchronous to clk.
REQ-007 Boton_Jugar  input  1  play request, level signal already synchronous to clk.
REQ-008 Nivel_Comida  output  2  food level, 0 = empty, 3 = full.
REQ-009 Nivel_Sueno  output  2  rest level, 0 to 3.
REQ-010 Nivel_Diversion  output  2  fun level, 0 to 3.
REQ-011 Visualizacion  output  2  action being shown: 0 = none, 1 = comer, 2 = dormir, 3 = jugar.
REQ-012 Ocupado  output  1  high while the FSM is in ACCION.
REQ-013 Alerta  output  1  high, registered, while any level equals 0.

Function
REQ-014 Request capture: a rising edge on a button (sampled 1, previous sample 0) SHALL set that need's pending bit at the same clock edge.
REQ-015 A rising edge on a button whose pending bit is already set, or whose action is running, SHALL be ignored.
REQ-016 The FSM SHALL have two states: IDLE and ACCION.
REQ-017 In IDLE with at least one pending bit, the next edge SHALL grant exactly one request, chosen round-robin.
REQ-018 Round-robin order SHALL be comida, sueno, diversion; the search SHALL start after the last granted need.
REQ-019 After reset the round-robin search SHALL start at comida.
REQ-020 A grant SHALL clear the granted pending bit.
REQ-021 If the granted need's level is 3, the grant SHALL be discarded: the FSM stays in IDLE, no Visualizacion change, and the pointer still advances.
REQ-022 Otherwise the grant SHALL move the FSM to ACCION, set Visualizacion to the need's code, and set Ocupado to 1.
REQ-023 ACCION SHALL last exactly ACCION_CICLOS cycles.
REQ-024 On the exit edge of ACCION: the served level increments by 1 (saturating at 3), Visualizacion becomes 0, Ocupado becomes 0, and the FSM returns to IDLE.
REQ-025 Decay prescaler: a free-running counter SHALL count 0 to TICKS_DECAY-1 and wrap; a tick SHALL occur on the wrap edge.
REQ-026 On each tick, every level SHALL decrement by 1, saturating at 0.
REQ-027 On a tick, the level of the need currently in ACCION SHALL NOT decrement.
REQ-028 If a tick and an ACCION exit fall on the same edge, the served need SHALL increment only, and the other needs SHALL decrement.
REQ-029 The prescaler SHALL NOT be affected by button activity or by the FSM state.
REQ-030 Requests arriving during ACCION for other needs SHALL be latched as pending and served afterwards, in round-robin order.
REQ-031 Simultaneous rising edges on several buttons SHALL set all corresponding pending bits on the same edge.

Reset
REQ-032 While reset is high, and asynchronously on its assertion, the block SHALL set:
- all levels to 3;
- Visualizacion to 0, Ocupado to 0, Alerta to 0;
- pending bits to 0 and button history registers to 0;
- prescaler and action counter to 0;
- the FSM to IDLE and the round-robin pointer to comida.
REQ-033 Reset asserted mid-ACCION SHALL abort the action without incrementing any level.
REQ-034 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Verification (TICKS_DECAY=100, ACCION_CICLOS=8)
REQ-035 The bench SHALL cover: no buttons for 250 cycles after reset -> all levels 2 at cycle 100 and 1 at cycle 200; Alerta 0.
REQ-036 The bench SHALL cover: no buttons for 300+ cycles -> all levels 0, Alerta 1; a further tick keeps them at 0.
REQ-037 The bench SHALL cover: levels at 1, single 1-cycle Boton_Comida pulse -> Visualizacion=1 and Ocupado=1 two edges later for 8 cycles; then Nivel_Comida=2 and Visualizacion=0.
REQ-038 The bench SHALL cover: all three buttons pulsed on the same cycle with levels below 3 -> served in order 1, 2, 3 back-to-back; each level +1.
REQ-039 The bench SHALL cover: Boton_Jugar pressed with Nivel_Diversion=3 -> pending cleared, Visualizacion stays 0, level stays 3.
REQ-040 The bench SHALL cover: reset asserted at cycle 4 of a dormir action -> Visualizacion=0 and all levels 3 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/control_necesidades_if.sv
// Button inputs and status outputs of the needs controller.
// The testbench drives the master side and the controller sits on the slave side.
interface control_necesidades_if;
    logic       Boton_Comida;
    logic       Boton_Dormir;
    logic       Boton_Jugar;
    logic [1:0] Nivel_Comida;
    logic [1:0] Nivel_Sueno;
    logic [1:0] Nivel_Diversion;
    logic [1:0] Visualizacion;
    logic       Ocupado;
    logic       Alerta;

    modport master (
        output Boton_Comida, Boton_Dormir, Boton_Jugar,
        input  Nivel_Comida, Nivel_Sueno, Nivel_Diversion, Visualizacion, Ocupado, Alerta
    );

    modport slave (
        input  Boton_Comida, Boton_Dormir, Boton_Jugar,
        output Nivel_Comida, Nivel_Sueno, Nivel_Diversion, Visualizacion, Ocupado, Alerta
    );
endinterface

// File: rtl/control_necesidades.sv
// Needs controller: buttons latch requests, a round-robin IDLE/ACCION FSM serves them,
// and a free-running prescaler decays all three levels. Index 0=comida, 1=sueno, 2=diversion.
module control_necesidades #(
    parameter int TICKS_DECAY   = 1000,
    parameter int ACCION_CICLOS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    control_necesidades_if.slave bus
);
    localparam int PW = (TICKS_DECAY > 1) ? $clog2(TICKS_DECAY) : 1;
    localparam int CW = $clog2(ACCION_CICLOS + 1);

    typedef enum logic {IDLE, ACCION} state_t;

    state_t          state_q, state_d;
    logic [2:0]      btn, btn_prev_q, rise, busy, grant_oh;
    logic [2:0]      pend_q, pend_d;
    logic [1:0]      sel_q, sel_d, last_q, last_d, cand, rr_idx;
    logic [2:0][1:0] lvl_q, lvl_d;
    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            alerta_q, alerta_d;
    logic            found, grant, accept, done, tick;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign btn    = {bus.Boton_Jugar, bus.Boton_Dormir, bus.Boton_Comida};
    assign rise   = btn & ~btn_prev_q;
    assign tick   = (presc_q == PW'(TICKS_DECAY - 1));
    assign done   = (state_q == ACCION) && (cnt_q == CW'(ACCION_CICLOS - 1));
    assign busy   = (state_q == ACCION) ? (3'b001 << sel_q) : 3'b000;

    // Round-robin search starts just after the last granted need.
    always_comb begin
        found  = 1'b0;
        cand   = 2'd0;
        rr_idx = last_q;
        for (int k = 0; k < 3; k++) begin
            rr_idx = nxt(rr_idx);
            if (!found && pend_q[rr_idx]) begin
                found = 1'b1;
                cand  = rr_idx;
            end
        end
    end

    assign grant    = found && (state_q == IDLE);
    assign accept   = grant && (lvl_q[cand] != 2'd3);
    assign grant_oh = grant ? (3'b001 << cand) : 3'b000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCION;
            ACCION:  if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Ocupado       = (state_q == ACCION);
        bus.Visualizacion = (state_q == ACCION) ? sel_q + 2'd1 : 2'd0;
        bus.Nivel_Comida    = lvl_q[0];
        bus.Nivel_Sueno     = lvl_q[1];
        bus.Nivel_Diversion = lvl_q[2];
        bus.Alerta        = alerta_q;
    end

    // The need being served is shielded from decay; it gains one level on the exit edge.
    always_comb begin
        pend_d   = (pend_q & ~grant_oh) | (rise & ~busy);
        last_d   = grant  ? cand : last_q;
        sel_d    = accept ? cand : sel_q;
        cnt_d    = (accept || done) ? '0 : (state_q == ACCION) ? cnt_q + 1'b1 : cnt_q;
        lvl_d    = lvl_q;
        alerta_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done && sel_q == 2'(i)) begin
                if (lvl_q[i] != 2'd3) lvl_d[i] = lvl_q[i] + 2'd1;
            end else if (tick && !busy[i] && lvl_q[i] != 2'd0) begin
                lvl_d[i] = lvl_q[i] - 2'd1;
            end
            if (lvl_d[i] == 2'd0) alerta_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q <= '0;
            pend_q     <= '0;
            sel_q      <= 2'd0;
            last_q     <= 2'd2;
            cnt_q      <= '0;
            presc_q    <= '0;
            lvl_q      <= {3{2'd3}};
            alerta_q   <= 1'b0;
        end else begin
            btn_prev_q <= btn;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            presc_q    <= tick ? '0 : presc_q + 1'b1;
            lvl_q      <= lvl_d;
            alerta_q   <= alerta_d;
        end
    end
endmodule

// File: tb/tb_control_necesidades.sv
// Directed bench for control_necesidades (TICKS_DECAY=100, ACCION_CICLOS=8): stimulus queues
// expected actions, a monitor checks each one as Ocupado rises and falls.
module tb_control_necesidades;
    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        int start;
        int vis;
        int nc, ns, nd;
        int dur;
    } exp_t;

    exp_t exp_q[$];

    control_necesidades_if bus();

    control_necesidades #(.TICKS_DECAY(100), .ACCION_CICLOS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_lv(input string tag, input int nc, input int ns, input int nd);
        chk({tag, ".comida"},    bus.Nivel_Comida,    nc);
        chk({tag, ".sueno"},     bus.Nivel_Sueno,     ns);
        chk({tag, ".diversion"}, bus.Nivel_Diversion, nd);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_cyc: reached cycle %0d, expected %0d", cyc, n);
        end
    endtask

    task automatic press(input logic [2:0] m);
        bus.Boton_Comida = m[0];
        bus.Boton_Dormir = m[1];
        bus.Boton_Jugar  = m[2];
        @(negedge clk);
        bus.Boton_Comida = 1'b0;
        bus.Boton_Dormir = 1'b0;
        bus.Boton_Jugar  = 1'b0;
    endtask

    task automatic push(input int st, input int vis, input int nc, input int ns, input int nd,
                        input int dur);
        exp_t e;
        e.start = st; e.vis = vis; e.nc = nc; e.ns = ns; e.nd = nd; e.dur = dur;
        exp_q.push_back(e);
    endtask

    // Monitor: action start time/code on Ocupado rise; length and resulting levels on its fall.
    initial begin
        logic ocu_prev = 1'b0;
        int   dur_cnt  = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (bus.Ocupado && !ocu_prev) begin
                dur_cnt = 1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_action: got vis %0d at cycle %0d, expected none",
                             bus.Visualizacion, cyc);
                end else begin
                    cur = exp_q[0];
                    chk("act_start", cyc, cur.start);
                    chk("act_vis", bus.Visualizacion, cur.vis);
                end
            end else if (bus.Ocupado) begin
                dur_cnt++;
            end else if (ocu_prev && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("act_dur", dur_cnt, cur.dur);
                chk("act_end_vis", bus.Visualizacion, 0);
                chk_lv("act_end", cur.nc, cur.ns, cur.nd);
            end
            ocu_prev = bus.Ocupado;
        end
    end

    initial begin
        reset = 1'b1;
        bus.Boton_Comida = 1'b0;
        bus.Boton_Dormir = 1'b0;
        bus.Boton_Jugar  = 1'b0;
        repeat (3) @(negedge clk);
        chk_lv("rst", 3, 3, 3);
        chk("rst.vis", bus.Visualizacion, 0);
        chk("rst.ocupado", bus.Ocupado, 0);
        chk("rst.alerta", bus.Alerta, 0);
        reset = 1'b0;

        // Decay only, then a single comida action at level 1.
        wait_cyc(99);  chk_lv("pre_tick", 3, 3, 3);
        wait_cyc(100); chk_lv("tick1", 2, 2, 2);
        wait_cyc(200); chk_lv("tick2", 1, 1, 1); chk("tick2.alerta", bus.Alerta, 0);
        wait_cyc(210); push(212, 1, 2, 1, 1, 8); press(3'b001);
        wait_cyc(214); press(3'b001);
        wait_cyc(240); chk("a.ocupado", bus.Ocupado, 0); chk("a.comida", bus.Nivel_Comida, 2);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Simultaneous presses served comida, sueno, diversion from the reset pointer.
        wait_cyc(100); chk_lv("b.tick1", 2, 2, 2);
        wait_cyc(105);
        push(107, 1, 3, 2, 2, 8);
        push(116, 2, 3, 3, 2, 8);
        push(125, 3, 3, 3, 3, 8);
        press(3'b111);
        wait_cyc(140); chk_lv("b.full", 3, 3, 3); press(3'b100);
        wait_cyc(142); chk("discard.vis", bus.Visualizacion, 0); chk("discard.ocupado", bus.Ocupado, 0);
        wait_cyc(145); chk("discard.vis2", bus.Visualizacion, 0); chk("discard.div", bus.Nivel_Diversion, 3);

        // Requests arriving during an action are latched and served afterwards.
        wait_cyc(200); chk_lv("b.tick2", 2, 2, 2);
        wait_cyc(205); push(207, 1, 3, 2, 2, 8); press(3'b001);
        wait_cyc(209); push(216, 2, 3, 3, 2, 8); push(225, 3, 3, 3, 3, 8); press(3'b110);
        wait_cyc(240); chk_lv("b.served", 3, 3, 3); chk("b.ocupado", bus.Ocupado, 0);

        // Action exit coincides with the decay tick at cycle 400.
        wait_cyc(390); push(392, 2, 1, 3, 1, 8); press(3'b010);
        wait_cyc(499); chk_lv("pre500", 1, 3, 1); chk("pre500.alerta", bus.Alerta, 0);
        wait_cyc(500); chk_lv("t500", 0, 2, 0); chk("t500.alerta", bus.Alerta, 1);
        wait_cyc(700); chk_lv("t700", 0, 0, 0); chk("t700.alerta", bus.Alerta, 1);
        wait_cyc(800); chk_lv("t800", 0, 0, 0); chk("t800.alerta", bus.Alerta, 1);

        // Reset on the fourth cycle of a dormir action aborts it immediately.
        wait_cyc(810); push(812, 2, 3, 3, 3, 4); press(3'b010);
        wait_cyc(815); chk("abort.ocupado", bus.Ocupado, 1); chk("abort.vis", bus.Visualizacion, 2);
        #2 reset = 1'b1;
        #1;
        chk("abort.vis0", bus.Visualizacion, 0);
        chk("abort.ocupado0", bus.Ocupado, 0);
        chk("abort.alerta", bus.Alerta, 0);
        chk_lv("abort", 3, 3, 3);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
